// File: rtl/nbcac_pkg.sv
// ---------------------------------------------------------------------------
// nbcac_pkg
// Shared definitions for the NBCAC receive path.
//  - Supported code/data width pairs. The 14/10 pair is the default.
//  - Fibonacci helper that gives the decoder its transition weights.
//  - Lane slice helper for the flat multi-lane buses.
//  - Saturation constant for the error counter.
// Code model: a word is legal when no three adjacent wires show 010 or 101.
// The transition vector t[j] = d[j+1]^d[j] then has no two adjacent ones.
// Its Zeckendorf rank plus d[0]*fib(CODE_W+1) gives the data value.
// Values that do not fit in DATA_W bits are also illegal.
// ---------------------------------------------------------------------------
package nbcac_pkg;

    localparam int DEF_CODE_W = 14;
    localparam int DEF_DATA_W = 10;

    typedef struct packed {
        int unsigned code_w;
        int unsigned data_w;
    } size_pair_t;

    // Each pair satisfies 2*fib(code_w+1) >= 2**data_w.
    localparam size_pair_t SIZE_PAIRS [4] = '{
        '{code_w: 5,  data_w: 4},
        '{code_w: 8,  data_w: 6},
        '{code_w: 11, data_w: 8},
        '{code_w: 14, data_w: 10}
    };

    // fib(1) = fib(2) = 1
    function automatic int fib(input int n);
        int a;
        int b;
        int s;
        a = 1;
        b = 1;
        for (int i = 3; i <= n; i++) begin
            s = a + b;
            a = b;
            b = s;
        end
        return b;
    endfunction

    // Low bit of lane 'lane' in a flat bus of 'w'-bit lanes.
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // Largest value an error counter of width 'w' can hold.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/nbcac_decoder_core.sv
// ---------------------------------------------------------------------------
// nbcac_decoder_core
// Purely combinational decoder for one lane.
// Ports:
//   d      in   CODE_W  code word (bit 0 = wire 0)
//   v      out  DATA_W  decoded value, truncated to DATA_W bits
//   legal  out  1       word is forbidden-pattern free and its value fits
// ---------------------------------------------------------------------------
module nbcac_decoder_core
    import nbcac_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [CODE_W-1:0] d,
    output logic [DATA_W-1:0] v,
    output logic              legal
);

    // One spare bit holds the largest sum, including the sum for illegal words.
    localparam int ACC_W = CODE_W + 1;
    localparam logic [ACC_W-1:0] BASE  = ACC_W'(fib(CODE_W + 1));
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(1) << DATA_W;

    logic [CODE_W-2:0] t;
    logic [ACC_W-1:0]  acc;
    logic              fpf;

    assign t = d[CODE_W-1:1] ^ d[CODE_W-2:0];

    // NOTE: every variable gets a value before the loop so no latch is inferred.
    always_comb begin
        acc = d[0] ? BASE : '0;
        fpf = 1'b1;
        for (int j = 0; j < CODE_W - 1; j++) begin
            if (t[j]) acc = acc + ACC_W'(fib(j + 2));
        end
        // Two adjacent transitions mean a 010 or 101 triple on the wires.
        for (int j = 1; j < CODE_W - 1; j++) begin
            if (t[j] && t[j-1]) fpf = 1'b0;
        end
    end

    assign v     = acc[DATA_W-1:0];
    assign legal = fpf && (acc < LIMIT);

endmodule

// File: rtl/nbcac_decoder_stream.sv
// ---------------------------------------------------------------------------
// nbcac_decoder_stream
// Streaming multi-lane NBCAC decoder with back-pressure and error accounting.
// Data path: code beat -> S1 register -> per-lane core -> 2-entry skid FIFO.
// Ports:
//   clock, rst_n            rising-edge clock, async active-low reset
//   in_valid/in_ready       code beat handshake; codein has LANES*CODE_W bits
//   out_valid/out_ready     data beat handshake; dataout has LANES*DATA_W bits
//   lane_err  out LANES     per-lane illegal flag, qualified by out_valid
//   err_sticky out 1        set when a delivered beat has an error
//   err_count  out CNT_W    saturating count of delivered beats with errors
//   err_clr    in  1        synchronous clear; wins over a same-cycle count
// ---------------------------------------------------------------------------
module nbcac_decoder_stream
    import nbcac_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*CODE_W-1:0] codein,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] dataout,
    output logic [LANES-1:0]        lane_err,
    output logic                    err_sticky,
    output logic [CNT_W-1:0]        err_count,
    input  logic                    err_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic                    live;      // low until the first edge after reset
    logic                    s1_valid;
    logic [LANES*CODE_W-1:0] s1_code;
    logic [1:0]              count;     // skid FIFO occupancy, 0..2
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [LANES*DATA_W-1:0] buf_data [2];
    logic [LANES-1:0]        buf_err  [2];

    logic [LANES*DATA_W-1:0] dec_data;
    logic [LANES-1:0]        dec_legal;
    logic [1:0]              in_flight;
    logic                    accept;
    logic                    push;
    logic                    pop;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        nbcac_decoder_core #(
            .CODE_W (CODE_W),
            .DATA_W (DATA_W)
        ) u_core (
            .d     (s1_code[lane_lo(k, CODE_W) +: CODE_W]),
            .v     (dec_data[lane_lo(k, DATA_W) +: DATA_W]),
            .legal (dec_legal[k])
        );
    end

    // The FIFO and S1 together never hold more than 2 beats. So when S1 is
    // full the FIFO has room, and S1 drains into it on every cycle.
    assign in_flight = count + {1'b0, s1_valid};
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid;
    assign in_ready  = live && ((in_flight < 2'd2) || pop);
    assign accept    = in_valid && in_ready;

    assign out_valid = (count != 2'd0);
    assign dataout   = out_valid ? buf_data[rd_ptr] : '0;
    assign lane_err  = out_valid ? buf_err[rd_ptr]  : '0;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            s1_valid   <= 1'b0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            live     <= 1'b1;
            s1_valid <= accept;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (err_clr) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end else if (pop && |lane_err) begin
                err_sticky <= 1'b1;
                if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
            end
        end
    end

    // NOTE: the payload storage is not reset. The valid bits and the output
    // gating above already hide stale contents.
    always_ff @(posedge clock) begin
        if (accept) s1_code <= codein;
        if (push) begin
            buf_data[wr_ptr] <= dec_data;
            buf_err[wr_ptr]  <= ~dec_legal;
        end
    end

endmodule
